// File: rtl/uart_byte_receiver.sv
// Oversampling 8N1 UART receiver for the program loader: delivers each good byte as a
// one-cycle rx_valid pulse, rejects start-bit glitches and flags stop-bit framing errors.
module uart_byte_receiver #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_serial_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error
);

  localparam int N     = CLKS_PER_BIT;
  localparam int H     = N / 2;
  localparam int CNT_W = $clog2(N);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(H - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_STOP      = 3'd4
  } state_t;

  logic             sync_meta_r;
  logic             line_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r;
  logic             frame_error_r;

  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign frame_error = frame_error_r;

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_r <= 1'b1;
      line_r      <= 1'b1;
    end else begin
      sync_meta_r <= uart_serial_rx;
      line_r      <= sync_meta_r;
    end
  end

  // Receive FSM: counters, shift register and registered output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_WAIT_IDLE;
      cnt_r         <= CNT_ZERO;
      bit_idx_r     <= 3'd0;
      shift_r       <= 8'h00;
      rx_data_r     <= 8'h00;
      rx_valid_r    <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      rx_valid_r    <= 1'b0;
      frame_error_r <= 1'b0;
      case (state_r)
        S_WAIT_IDLE: begin
          // Only a full bit time of continuous idle re-arms the receiver
          if (!line_r) begin
            cnt_r <= CNT_ZERO;
          end else if (cnt_r == LAST_CNT) begin
            cnt_r   <= CNT_ZERO;
            state_r <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_IDLE: begin
          cnt_r     <= CNT_ZERO;
          bit_idx_r <= 3'd0;
          if (!line_r) begin
            state_r <= S_START;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_START: begin
          if (cnt_r == MID_CNT) begin
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            if (line_r) begin
              state_r <= S_IDLE;
            end else begin
              state_r <= S_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r              <= CNT_ZERO;
            shift_r[bit_idx_r] <= line_r;
            if (bit_idx_r == 3'd7) begin
              state_r <= S_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_STOP: begin
          // Leaving at mid stop bit lets a zero-gap next start edge be caught
          if (cnt_r == LAST_CNT) begin
            cnt_r <= CNT_ZERO;
            if (line_r) begin
              rx_data_r  <= shift_r;
              rx_valid_r <= 1'b1;
              state_r    <= S_IDLE;
            end else begin
              frame_error_r <= 1'b1;
              state_r       <= S_WAIT_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= S_WAIT_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  uart_byte_receiver_checker u_checker (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid_r),
    .frame_error (frame_error_r)
  );

endmodule

// Output pulse properties of the receiver: exclusive and single-cycle.
module uart_byte_receiver_checker (
  input logic clk,
  input logic reset,
  input logic rx_valid,
  input logic frame_error
);

  a_exclusive: assert property (@(posedge clk) disable iff (reset) !(rx_valid && frame_error));
  a_valid_single: assert property (@(posedge clk) disable iff (reset) rx_valid |=> !rx_valid);
  a_ferr_single: assert property (@(posedge clk) disable iff (reset) frame_error |=> !frame_error);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver: frame-level reference model, N=8 and N=868 instances.
module tb_uart_byte_receiver;

  localparam int NA = 8;
  localparam int NB = 868;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] last_good [2];
  logic [7:0] aborted = 8'hF0;
  logic [7:0] rbyte;
  logic       rbad;

  uart_byte_receiver #(.CLKS_PER_BIT(NA)) dut_a (
    .clk(clk), .reset(reset), .uart_serial_rx(rx_a),
    .rx_data(data_a), .rx_valid(valid_a), .frame_error(ferr_a)
  );

  uart_byte_receiver #(.CLKS_PER_BIT(NB)) dut_b (
    .clk(clk), .reset(reset), .uart_serial_rx(rx_b),
    .rx_data(data_b), .rx_valid(valid_b), .frame_error(ferr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic hold(input int sel, input logic v, input int cycles);
    set_line(sel, v);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Whole-frame stimulus; the expected outcome is queued when the frame begins
  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop, input int per);
    exp_t e;
    e.is_err = !stop;
    e.data   = b;
    e.start  = cyc;
    if (sel == 0) q_a.push_back(e);
    else q_b.push_back(e);
    hold(sel, 1'b0, per);
    for (int i = 0; i < 8; i++) hold(sel, b[i], per);
    hold(sel, stop, per);
  endtask

  task automatic mon_one(input int sel, input logic v, input logic fe, input logic [7:0] d);
    exp_t  e;
    int    nom;
    int    lat;
    int    pending;
    string tag;
    if (!v && !fe) return;
    tag     = (sel == 0) ? "a" : "b";
    nom     = (sel == 0) ? (2 + NA / 2 + 9 * NA + 1) : (2 + NB / 2 + 9 * NB + 1);
    pending = (sel == 0) ? q_a.size() : q_b.size();
    chk({tag, "_pulse_exclusive"}, int'(v & fe), 0);
    if (pending == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_pulse: actual valid=%0b ferr=%0b data=%0h required no pulse",
               tag, v, fe, d);
      return;
    end
    if (sel == 0) e = q_a.pop_front();
    else e = q_b.pop_front();
    lat = cyc - e.start;
    chk({tag, "_frame_error"}, int'(fe), int'(e.is_err));
    chk({tag, "_rx_valid"}, int'(v), int'(!e.is_err));
    if (!e.is_err) begin
      chk({tag, "_rx_data"}, int'(d), int'(e.data));
      last_good[sel] = e.data;
    end else begin
      chk({tag, "_data_held"}, int'(d), int'(last_good[sel]));
    end
    checks++;
    if (lat < nom - 1 || lat > nom + 1) begin
      errors++;
      $display("FAIL %s_latency: actual=%0d required=%0d+/-1", tag, lat, nom);
    end
  endtask

  task automatic drain(input string nm, input int limit);
    int n = 0;
    while ((q_a.size() + q_b.size()) > 0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if ((q_a.size() + q_b.size()) != 0) begin
      errors++;
      $display("FAIL %s_missing_pulse: actual pending=%0d required 0", nm, q_a.size() + q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  initial begin
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    fork
      forever begin
        @(negedge clk);
        mon_one(0, valid_a, ferr_a, data_a);
        mon_one(1, valid_b, ferr_b, data_b);
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_a_data", int'(data_a), 0);
    chk("reset_a_valid", int'(valid_a), 0);
    chk("reset_a_ferr", int'(ferr_a), 0);
    chk("reset_b_data", int'(data_b), 0);
    chk("reset_b_valid", int'(valid_b), 0);
    chk("reset_b_ferr", int'(ferr_b), 0);

    // Single byte after idle
    hold(0, 1'b1, 16);
    send_frame(0, 8'hA5, 1'b1, NA);
    hold(0, 1'b1, 4);
    drain("t1", 200);

    // Back-to-back frames, no idle gap
    send_frame(0, 8'h00, 1'b1, NA);
    send_frame(0, 8'hFF, 1'b1, NA);
    hold(0, 1'b1, 4);
    drain("t2", 200);

    // Start-bit glitch is ignored
    hold(0, 1'b0, 2);
    hold(0, 1'b1, 20);
    send_frame(0, 8'h3C, 1'b1, NA);
    hold(0, 1'b1, 4);
    drain("t3", 200);

    // Framing error, line held low, then recovery
    send_frame(0, 8'h11, 1'b1, NA);
    send_frame(0, 8'h55, 1'b0, NA);
    hold(0, 1'b0, 30);
    hold(0, 1'b1, 16);
    chk("t4_data_held", int'(data_a), 8'h11);
    send_frame(0, 8'h12, 1'b1, NA);
    hold(0, 1'b1, 4);
    drain("t4", 200);

    // Reset in the middle of a frame
    hold(0, 1'b0, NA);
    for (int i = 0; i < 4; i++) hold(0, aborted[i], NA);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    chk("t5_a_data", int'(data_a), 0);
    chk("t5_a_valid", int'(valid_a), 0);
    chk("t5_a_ferr", int'(ferr_a), 0);
    chk("t5_b_data", int'(data_b), 0);
    for (int i = 4; i < 8; i++) hold(0, aborted[i], NA);
    hold(0, 1'b1, NA);
    hold(0, 1'b1, 16);
    send_frame(0, 8'h7E, 1'b1, NA);
    hold(0, 1'b1, 4);
    drain("t5", 200);

    // Random bytes with random gaps and occasional bad stop bits
    for (int i = 0; i < 12; i++) begin
      rbyte = 8'($urandom_range(0, 255));
      rbad  = ($urandom_range(0, 5) == 0);
      send_frame(0, rbyte, !rbad, NA);
      if (rbad) hold(0, 1'b1, 12 + int'($urandom_range(0, 8)));
      else hold(0, 1'b1, int'($urandom_range(0, 10)));
    end
    hold(0, 1'b1, 4);
    drain("rand", 300);

    // 115200 baud at 100 MHz, nominal and +/-2% bit period
    hold(1, 1'b1, 1000);
    send_frame(1, 8'hC3, 1'b1, NB);
    hold(1, 1'b1, 100);
    drain("t6_nominal", 2000);
    send_frame(1, 8'hC3, 1'b1, (NB * 102) / 100);
    hold(1, 1'b1, 1000);
    drain("t6_slow", 2000);
    send_frame(1, 8'hC3, 1'b1, (NB * 98) / 100);
    hold(1, 1'b1, 1000);
    drain("t6_fast", 2000);

    hold(0, 1'b1, 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
